// File: rtl/hsb_axis_avst_shim_if.sv
// ---------------------------------------------------------------------------
// hsb_axis_avst_shim_if
//
// Purpose:
//    Bundles the AXI4-Stream input side and the Avalon-ST output side of the
//    HSB AXIS -> Avalon-ST shim into one interface. The bridge instance uses
//    the slave view. An upstream producer / downstream consumer pair (or a
//    testbench) uses the master view.
//
// Parameters:
//    C_S_AXIS_TDATA_WIDTH  tdata / Avalon data width (multiple of 8)
//    C_AV_EMPTY_WIDTH      width of av_src_empty
//    C_AXIS_TUSER_WIDTH    width of tuser (bit 0 = start of packet)
//
// Signals:
//    s_axis_tdata / tkeep / tlast / tuser / tvalid   AXIS beat from producer
//    s_axis_tready                                  AXIS ready from bridge
//    av_src_data / startofpacket / endofpacket /
//    av_src_empty / av_src_valid                    Avalon-ST beat from bridge
//    av_src_ready                                   Avalon ready from consumer
// ---------------------------------------------------------------------------
interface hsb_axis_avst_shim_if #(
   parameter int C_S_AXIS_TDATA_WIDTH = 96,
   parameter int C_AV_EMPTY_WIDTH     = 4,
   parameter int C_AXIS_TUSER_WIDTH   = 1
);

   localparam int C_BYTES = C_S_AXIS_TDATA_WIDTH / 8;

   // AXI4-Stream side
   logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata;
   logic [C_BYTES-1:0]              s_axis_tkeep;
   logic                            s_axis_tlast;
   logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser;
   logic                            s_axis_tvalid;
   logic                            s_axis_tready;

   // Avalon-ST side
   logic [C_S_AXIS_TDATA_WIDTH-1:0] av_src_data;
   logic                            av_src_startofpacket;
   logic                            av_src_endofpacket;
   logic [C_AV_EMPTY_WIDTH-1:0]     av_src_empty;
   logic                            av_src_valid;
   logic                            av_src_ready;

   // Bridge view: consumes AXIS beats, sources Avalon-ST beats
   modport slave (
      input  s_axis_tdata,
      input  s_axis_tkeep,
      input  s_axis_tlast,
      input  s_axis_tuser,
      input  s_axis_tvalid,
      output s_axis_tready,
      output av_src_data,
      output av_src_startofpacket,
      output av_src_endofpacket,
      output av_src_empty,
      output av_src_valid,
      input  av_src_ready
   );

   // Environment view: produces AXIS beats, sinks Avalon-ST beats
   modport master (
      output s_axis_tdata,
      output s_axis_tkeep,
      output s_axis_tlast,
      output s_axis_tuser,
      output s_axis_tvalid,
      input  s_axis_tready,
      input  av_src_data,
      input  av_src_startofpacket,
      input  av_src_endofpacket,
      input  av_src_empty,
      input  av_src_valid,
      output av_src_ready
   );

endinterface

// File: rtl/hsb_axis_avst_shim.sv
// ---------------------------------------------------------------------------
// hsb_axis_avst_shim
//
// Purpose:
//    AXI4-Stream slave to Avalon-ST source bridge for the HSB subsystem.
//    Each accepted AXIS beat is converted (optional byte swap, tlast->eop,
//    tkeep->empty, SOP generation) and stored in a 2-entry skid buffer made
//    of an output register plus one skid register. Both s_axis_tready and
//    av_src_valid are driven directly from flops. A beat appears on the
//    Avalon side one cycle after it is accepted. The bridge sustains one
//    beat per cycle while the consumer keeps av_src_ready high.
//
// Parameters:
//    C_BYTE_SWAP          1: reverse byte order of tdata, 0: pass through
//    C_S_AXIS_TDATA_WIDTH data width, multiple of 8
//    C_AV_EMPTY_WIDTH     av_src_empty width, must hold C_BYTES-1
//    C_AXIS_TUSER_WIDTH   tuser width, only bit 0 is used
//    C_SOP_FROM_TUSER     1: sop = tuser[0], 0: sop from packet tracker
//
// Ports:
//    clk        single clock domain
//    resetn     asynchronous active-low reset, synchronous release assumed
//    bus        AXIS input / Avalon-ST output bundle (slave view)
//    err_tkeep  1-cycle pulse after an accepted beat with an illegal tkeep
// ---------------------------------------------------------------------------
module hsb_axis_avst_shim #(
   parameter int C_BYTE_SWAP          = 1,
   parameter int C_S_AXIS_TDATA_WIDTH = 96,
   parameter int C_AV_EMPTY_WIDTH     = 4,
   parameter int C_AXIS_TUSER_WIDTH   = 1,
   parameter int C_SOP_FROM_TUSER     = 0
) (
   input  logic                 clk,
   input  logic                 resetn,
   hsb_axis_avst_shim_if.slave  bus,
   output logic                 err_tkeep
);

   localparam int C_BYTES = C_S_AXIS_TDATA_WIDTH / 8;

   // Skid buffer occupancy: EMPTY = nothing held, BUSY = output register
   // holds a beat, FULL = output and skid registers both hold a beat.
   typedef enum logic [1:0] {
      SKID_EMPTY,
      SKID_BUSY,
      SKID_FULL
   } skid_state_t;

   // Packet tracker: IDLE = next accepted beat starts a packet.
   typedef enum logic {
      TRK_IDLE,
      TRK_INPKT
   } trk_state_t;

   skid_state_t skid_state;
   skid_state_t skid_next;
   trk_state_t  trk_state;
   trk_state_t  trk_next;

   logic accept;
   logic xfer;
   logic load_out_from_in;
   logic load_out_from_skid;
   logic load_skid;

   // Beat as converted at accept time
   logic [C_S_AXIS_TDATA_WIDTH-1:0] conv_data;
   logic                            conv_sop;
   logic                            conv_eop;
   logic [C_AV_EMPTY_WIDTH-1:0]     conv_empty;
   logic                            conv_err;
   logic [C_BYTES-1:0]              keep_inc;
   logic                            keep_contig;
   int                              keep_pop;

   // Output register (what the Avalon side currently sees)
   logic [C_S_AXIS_TDATA_WIDTH-1:0] out_data;
   logic                            out_sop;
   logic                            out_eop;
   logic [C_AV_EMPTY_WIDTH-1:0]     out_empty;
   logic                            out_valid;

   // Skid register (second beat held while the consumer stalls)
   logic [C_S_AXIS_TDATA_WIDTH-1:0] skid_data;
   logic                            skid_sop;
   logic                            skid_eop;
   logic [C_AV_EMPTY_WIDTH-1:0]     skid_empty;

   logic tready_q;
   logic err_q;

   assign accept = bus.s_axis_tvalid & tready_q;
   assign xfer   = out_valid & bus.av_src_ready;

   assign bus.s_axis_tready        = tready_q;
   assign bus.av_src_valid         = out_valid;
   assign bus.av_src_data          = out_data;
   assign bus.av_src_startofpacket = out_sop;
   assign bus.av_src_endofpacket   = out_eop;
   assign bus.av_src_empty         = out_empty;
   assign err_tkeep                = err_q;

   // Convert the incoming AXIS beat into its Avalon-ST form. tkeep is
   // expected to be LSB-first contiguous (2^n-1), which is the case exactly
   // when tkeep & (tkeep+1) is zero. A fully cleared tkeep on a tlast beat
   // cannot be expressed as an empty count, so it reports the largest legal
   // value and is flagged as an error.
   always_comb begin
      conv_data   = bus.s_axis_tdata;
      keep_pop    = 0;
      keep_inc    = bus.s_axis_tkeep + C_BYTES'(1);
      keep_contig = ((bus.s_axis_tkeep & keep_inc) == '0);

      if (C_BYTE_SWAP != 0) begin
         for (int i = 0; i < C_BYTES; i++) begin
            conv_data[8*i +: 8] = bus.s_axis_tdata[8*(C_BYTES-1-i) +: 8];
         end
      end

      for (int i = 0; i < C_BYTES; i++) begin
         if (bus.s_axis_tkeep[i]) begin
            keep_pop = keep_pop + 1;
         end
      end

      conv_eop   = bus.s_axis_tlast;
      conv_empty = '0;
      if (bus.s_axis_tlast) begin
         if (bus.s_axis_tkeep == '0) begin
            conv_empty = C_AV_EMPTY_WIDTH'(C_BYTES - 1);
         end else begin
            conv_empty = C_AV_EMPTY_WIDTH'(C_BYTES - keep_pop);
         end
      end

      conv_err = !keep_contig
               || (!bus.s_axis_tlast && !(&bus.s_axis_tkeep))
               || (bus.s_axis_tlast && (bus.s_axis_tkeep == '0));

      conv_sop = (C_SOP_FROM_TUSER != 0) ? bus.s_axis_tuser[0]
                                         : (trk_state == TRK_IDLE);
   end

   // Packet tracker next state: every accepted beat either opens a packet
   // (from IDLE) or continues it, and a tlast beat always closes it, which
   // also covers single-beat packets. Runs regardless of the SOP source.
   always_comb begin
      trk_next = trk_state;
      if (accept) begin
         trk_next = bus.s_axis_tlast ? TRK_IDLE : TRK_INPKT;
      end
   end

   // Skid FSM next state and register load selects. When the output register
   // is busy and the consumer stalls, a newly accepted beat parks in the skid
   // register; when the consumer takes the output beat, the skid beat moves
   // forward. tready is not offered in FULL, so no accept happens there.
   always_comb begin
      skid_next          = skid_state;
      load_out_from_in   = 1'b0;
      load_out_from_skid = 1'b0;
      load_skid          = 1'b0;

      case (skid_state)
         SKID_EMPTY: begin
            if (accept) begin
               skid_next        = SKID_BUSY;
               load_out_from_in = 1'b1;
            end
         end
         SKID_BUSY: begin
            if (accept && !xfer) begin
               skid_next = SKID_FULL;
               load_skid = 1'b1;
            end else if (accept && xfer) begin
               load_out_from_in = 1'b1;
            end else if (xfer) begin
               skid_next = SKID_EMPTY;
            end
         end
         SKID_FULL: begin
            if (xfer) begin
               skid_next          = SKID_BUSY;
               load_out_from_skid = 1'b1;
            end
         end
         default: begin
            skid_next = SKID_EMPTY;
         end
      endcase
   end

   // State registers. valid and ready are registered copies of the next
   // occupancy so that neither depends combinationally on the other side.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         skid_state <= SKID_EMPTY;
         trk_state  <= TRK_IDLE;
         out_valid  <= 1'b0;
         tready_q   <= 1'b1;
         err_q      <= 1'b0;
      end else begin
         skid_state <= skid_next;
         trk_state  <= trk_next;
         out_valid  <= (skid_next != SKID_EMPTY);
         tready_q   <= (skid_next != SKID_FULL);
         err_q      <= accept & conv_err;
      end
   end

   // Beat storage. The output register keeps its contents while stalled, so
   // the Avalon side stays stable until the transfer happens.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_data   <= '0;
         out_sop    <= 1'b0;
         out_eop    <= 1'b0;
         out_empty  <= '0;
         skid_data  <= '0;
         skid_sop   <= 1'b0;
         skid_eop   <= 1'b0;
         skid_empty <= '0;
      end else begin
         if (load_out_from_in) begin
            out_data  <= conv_data;
            out_sop   <= conv_sop;
            out_eop   <= conv_eop;
            out_empty <= conv_empty;
         end else if (load_out_from_skid) begin
            out_data  <= skid_data;
            out_sop   <= skid_sop;
            out_eop   <= skid_eop;
            out_empty <= skid_empty;
         end

         if (load_skid) begin
            skid_data  <= conv_data;
            skid_sop   <= conv_sop;
            skid_eop   <= conv_eop;
            skid_empty <= conv_empty;
         end
      end
   end

endmodule
